// File: rtl/zcash_fpga_rpl_arb.sv
// zcash_fpga_rpl_arb
//   Packet-atomic round-robin arbiter for the FPGA-to-host reply path.
//   Merges N_IN reply producers onto one host TX stream. A producer is
//   locked from its first beat through its eop, so replies never interleave.
//   Framing errors raise a sticky o_err flag. Forwarding is not affected.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no packet locked; scan requesters round-robin after last_ptr
//   LOCK  | producer `grant` passed straight through until eop transfers
//
// Ports
//   i_clk, i_rst          system clock, synchronous active-high reset
//   i_val/i_dat/i_sop/    per-producer beat streams (producer k in slice k)
//   i_eop/i_mod, o_rdy
//   o_val/o_dat/o_sop/    merged host stream, i_rdy is downstream ready
//   o_eop/o_mod, i_rdy
//   o_grant, o_busy       locked producer index, valid while o_busy=1
//   o_err                 sticky framing error
//   o_pkt_cnt             completed packet count (wraps)
module zcash_fpga_rpl_arb #(
  parameter int N_IN     = 2,
  parameter int DAT_BYTS = 8,
  parameter int MOD_BITS = $clog2(DAT_BYTS)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [N_IN-1:0]              i_val,
  input  logic [N_IN*DAT_BYTS*8-1:0]   i_dat,
  input  logic [N_IN-1:0]              i_sop,
  input  logic [N_IN-1:0]              i_eop,
  input  logic [N_IN*MOD_BITS-1:0]     i_mod,
  output logic [N_IN-1:0]              o_rdy,
  output logic                         o_val,
  output logic [DAT_BYTS*8-1:0]        o_dat,
  output logic                         o_sop,
  output logic                         o_eop,
  output logic [MOD_BITS-1:0]          o_mod,
  input  logic                         i_rdy,
  output logic [$clog2(N_IN)-1:0]      o_grant,
  output logic                         o_busy,
  output logic                         o_err,
  output logic [31:0]                  o_pkt_cnt
);

  localparam int GW = $clog2(N_IN);
  localparam int DW = DAT_BYTS * 8;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   last_ptr;
  logic [GW-1:0]   sel_idx;
  logic            sel_found;
  logic            first_beat;
  logic            err;
  logic [31:0]     pkt_cnt;
  logic            xfer;

  // Round-robin scan: first requester after last_ptr, wrapping modulo N_IN.
  always_comb begin
    int idx;
    idx       = 0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 1; i <= N_IN; i++) begin
      idx = int'(last_ptr) + i;
      if (idx >= N_IN) idx = idx - N_IN;
      if (!sel_found && i_val[idx]) begin
        sel_found = 1'b1;
        sel_idx   = GW'(idx);
      end
    end
  end

  // Zero-latency pass-through of the locked producer; everything idle otherwise.
  always_comb begin
    o_val = 1'b0;
    o_dat = '0;
    o_sop = 1'b0;
    o_eop = 1'b0;
    o_mod = '0;
    o_rdy = '0;
    if (state == LOCK) begin
      o_val        = i_val[grant];
      o_dat        = i_dat[int'(grant)*DW +: DW];
      o_sop        = i_sop[grant];
      o_eop        = i_eop[grant];
      o_mod        = i_mod[int'(grant)*MOD_BITS +: MOD_BITS];
      o_rdy[grant] = i_rdy;
    end
  end

  assign xfer = (state == LOCK) && o_val && i_rdy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_ptr   <= GW'(N_IN - 1);
      first_beat <= 1'b0;
      err        <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant      <= sel_idx;
            first_beat <= 1'b1;
            state      <= LOCK;
          end
        end
        LOCK: begin
          if (xfer) begin
            first_beat <= 1'b0;
            // Packet must open with sop and carry no second sop before eop.
            if (first_beat != o_sop) err <= 1'b1;
            if (o_eop) begin
              state    <= IDLE;
              last_ptr <= grant;
              pkt_cnt  <= pkt_cnt + 32'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_grant   = grant;
  assign o_busy    = (state == LOCK);
  assign o_err     = err;
  assign o_pkt_cnt = pkt_cnt;

endmodule
